seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Time-multiplexed seven-segment driver that sits downstream of the BCD counter stage and replaces the single-digit decoder on the output pins. It takes a packed vector of BCD digits and a load strobe and double-buffers them so a frame never shows mixed values. It scans one digit at a time with a dead-time gap between digits to suppress ghosting. Segment lines go to uo_out[6:0] and dp to uo_out[7]; one-hot digit enables go to uio_out.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- SCAN_DIV, 2500: clock cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 100: dead-time cycles at the start of each slot; must be less than SCAN_DIV; 0 disables dead time.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- digits_in  in  4*NUM_DIGITS  BCD digits; nibble i is digit i, and digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- load  in  1  one-cycle strobe that captures digits_in and dp_in into the pending buffer.
- lz_blank_en  in  1  enables leading-zero blanking.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp_out  out  1  decimal point, active-high.
- dig_en  out  NUM_DIGITS  one-hot digit enable, active-high.
- frame_start  out  1  one-cycle pulse on each wrap into slot 0.

## Operation
- **Slot timer.** The slot counter `cnt` counts 0..SCAN_DIV-1 and then wraps. On each wrap, the slot index `slot` advances modulo NUM_DIGITS, from 0 up to NUM_DIGITS-1 and back to 0.
- **State machine.**
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt >= BLANK_CYCLES.
  - BLANK→DRIVE when cnt reaches BLANK_CYCLES.
  - DRIVE→BLANK on the cnt wrap.
- **Outputs in BLANK.** dig_en = 0, seg_out = 0, dp_out = 0.
- **Outputs in DRIVE.**
  - dig_en = one-hot(slot).
  - seg_out = decode(active digit[slot]).
  - dp_out = active dp[slot].
- **Decode table (hex gfedcba).**
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66.
  - 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - 10..15→40, i.e. a dash flagging an invalid BCD code.
- **Double buffer.**
  - load writes the pending buffer and sets `pend_valid`.
  - On the cycle `slot` wraps NUM_DIGITS-1→0, if pend_valid is set: active ← pending and pend_valid is cleared.
- **Leading-zero blanking.** When lz_blank_en = 1:
  - Digit i (i ≥ 1) is blanked if it and every more significant active digit equal 0.
  - Digit 0 is never blanked.
  - A blanked digit in DRIVE gives dig_en = 0, seg_out = 0 and dp_out = 0; slot timing is unchanged.
  - lz_blank_en is sampled live, not buffered.
- **Load coinciding with a frame wrap.** The transfer uses the pending contents from before that cycle's load. The new data lands in pending, pend_valid stays 1, and the data is applied at the next wrap.

## Timing
- All outputs are registered, giving one cycle of latency from the cnt/slot state to the pins.
- **Reset values.** While rst_n = 0 at a clock edge:
  - Counters and state: cnt = 0, slot = 0, state BLANK.
  - Outputs: seg_out = 0, dp_out = 0, dig_en = 0, frame_start = 0.
  - Buffers: active = 0, pending = 0, pend_valid = 0.
- **First drive after reset.** Edge E0 is the first edge with rst_n = 1. dig_en[0] rises after edge E(BLANK_CYCLES) and holds for SCAN_DIV-BLANK_CYCLES cycles.
- **frame_start.**
  - High for exactly one cycle, coincident with the first BLANK output cycle of slot 0.
  - Not asserted for the frame started by reset.
  - Period is NUM_DIGITS*SCAN_DIV cycles.
- **New data visibility.** Data loaded mid-frame first appears on the pins in the frame flagged by the next frame_start.
- **Reset mid-operation.** Reset takes priority over everything: outputs are 0 on the next cycle and the pending data is discarded.
- **No overlap.** dig_en never has more than one bit set. The BLANK outputs always separate adjacent digits when BLANK_CYCLES > 0.

## Test plan
Bench parameters: NUM_DIGITS = 4, SCAN_DIV = 8, BLANK_CYCLES = 2.
1. **Reset.** Release reset with lz_blank_en = 0 → all outputs 0 for 2 cycles, then dig_en = 0001 and seg_out = 3F for 6 cycles, then 2 blank cycles, then dig_en = 0010 and seg_out = 3F. No overlap at any point.
2. **Load and scan order.** Load digits_in = 0x1234 and dp_in = 0100, then wait for frame_start → slots 0..3 show 66, 4F, 5B, 06. dp_out = 1 only in slot 2.
3. **Leading-zero blanking.** Load 0x0070 with lz_blank_en = 1 → slots 3 and 2 have dig_en = 0 and seg_out = 0; slot 1 shows 07; slot 0 shows 3F. With lz_blank_en = 0, slots 3 and 2 show 3F.
4. **Invalid BCD.** Load 0xA9F0 → slots 0..3 show 3F, 40, 6F, 40.
5. **Tear-free update.** Load 0x5555 during slot 2, then load 0x9999 on the frame-wrap cycle → the remainder of the frame is unchanged. The next frame shows 6D; the following frame shows 6F.
6. **Reset mid-operation.** Assert rst_n = 0 during DRIVE of slot 2 → all outputs 0 on the next cycle. After release the scan restarts in slot 0 with active = 0, showing 3F.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver: double-buffered BCD digits, one digit
// per slot with a dead-time gap, optional leading-zero blanking, registered pins.
module seg7_scan_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 2500,
   parameter int BLANK_CYCLES = 100
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    lz_blank_en,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_start
);

   localparam int CNT_W  = $clog2(SCAN_DIV);
   localparam int SLOT_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [SLOT_W-1:0]              slot_q;
   logic                           cnt_wrap, frame_wrap, wrap_q;
   logic [NUM_DIGITS-1:0][3:0]     active_dig, pend_dig;
   logic [NUM_DIGITS-1:0]          active_dp, pend_dp;
   logic                           pend_valid;
   logic [NUM_DIGITS-1:0]          lz_mask;
   logic                           zero_above;
   logic [6:0]                     seg_d;
   logic                           dp_d;
   logic [NUM_DIGITS-1:0]          dig_en_d;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   assign cnt_wrap   = (cnt_q == CNT_LAST);
   assign frame_wrap = cnt_wrap && (slot_q == SLOT_LAST);
   assign cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;

   // NOTE: every signal an always_comb writes gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_d >= CNT_BLANK) state_d = ST_DRIVE;
         ST_DRIVE: if (cnt_wrap && (BLANK_CYCLES != 0)) state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         slot_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= frame_wrap;
         if (cnt_wrap) slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
   end

   // A load on the wrap cycle lands in pending; the transfer still takes the old pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_dig <= '0;
         active_dp  <= '0;
         pend_dig   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (frame_wrap && pend_valid) begin
            active_dig <= pend_dig;
            active_dp  <= pend_dp;
         end
         if (load) begin
            pend_dig   <= digits_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
         end else if (frame_wrap) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // A digit is blanked when it and everything above it are zero; digit 0 always shows.
   always_comb begin
      zero_above = 1'b1;
      lz_mask    = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (active_dig[i] == 4'd0);
         lz_mask[i] = lz_blank_en && zero_above;
      end
   end

   always_comb begin
      seg_d    = '0;
      dp_d     = 1'b0;
      dig_en_d = '0;
      if ((state_q == ST_DRIVE) && !lz_mask[slot_q]) begin
         seg_d            = decode(active_dig[slot_q]);
         dp_d             = active_dp[slot_q];
         dig_en_d[slot_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_out     <= '0;
         dp_out      <= 1'b0;
         dig_en      <= '0;
         frame_start <= 1'b0;
      end else begin
         seg_out     <= seg_d;
         dp_out      <= dp_d;
         dig_en      <= dig_en_d;
         frame_start <= wrap_q;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a cycle-indexed frame model predicts every
// output cycle; a monitor pops and compares the registered pins.
module tb_seg7_scan_mux;

   localparam int N     = 4;
   localparam int SD    = 8;
   localparam int B     = 2;
   localparam int FRAME = N * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        lz_blank_en = 1'b0;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  dig_en;
   logic        frame_start;

   seg7_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
      .lz_blank_en(lz_blank_en), .seg_out(seg_out), .dp_out(dp_out),
      .dig_en(dig_en), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] dig;
      logic       fs;
   } exp_t;

   exp_t exp_q[$];
   int   phase_q[$];
   int   errors = 0;
   int   checks = 0;
   int   phase  = 0;
   bit   cur_lz = 1'b0;

   // Reference model: position in the frame is plain arithmetic on cycles since reset.
   logic [6:0] seg_tab[16];
   logic [3:0] m_act[N];
   logic [3:0] m_pend[N];
   logic       m_adp[N];
   logic       m_pdp[N];
   bit         m_pv;
   int         t;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit ld, input logic [15:0] d,
                             input logic [3:0] p, input bit lzb);
      exp_t e;
      int   cnt;
      int   slot;
      bit   blanked;
      e = '0;
      if (!r) begin
         t    = 0;
         m_pv = 0;
         for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_pend[i] = 0; m_adp[i] = 0; m_pdp[i] = 0;
         end
      end else begin
         cnt  = t % SD;
         slot = (t / SD) % N;
         blanked = 0;
         if (lzb && slot > 0) begin
            blanked = 1;
            for (int j = slot; j < N; j++) if (m_act[j] != 0) blanked = 0;
         end
         if (cnt >= B && !blanked) begin
            e.seg = seg_tab[m_act[slot]];
            e.dp  = m_adp[slot];
            e.dig = 4'(1 << slot);
         end
         e.fs = (t > 0) && (t % FRAME == 0);
         if ((t % FRAME == FRAME - 1) && m_pv) begin
            for (int i = 0; i < N; i++) begin
               m_act[i] = m_pend[i]; m_adp[i] = m_pdp[i];
            end
            m_pv = 0;
         end
         if (ld) begin
            for (int i = 0; i < N; i++) begin
               m_pend[i] = d[4*i +: 4]; m_pdp[i] = p[i];
            end
            m_pv = 1;
         end
         t++;
      end
      exp_q.push_back(e);
      phase_q.push_back(phase);
   endtask

   task automatic cycle(input bit r, input bit ld, input logic [15:0] d,
                        input logic [3:0] p, input bit lzb);
      @(negedge clk);
      rst_n       = r;
      load        = ld;
      digits_in   = d;
      dp_in       = p;
      lz_blank_en = lzb;
      model_step(r, ld, d, p, lzb);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b1, 1'b0, digits_in, dp_in, cur_lz);
   endtask

   task automatic idle_until(input int pos);
      for (int k = 0; k < FRAME && (t % FRAME) != pos; k++) idle(1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      cycle(1'b1, 1'b1, d, p, cur_lz);
   endtask

   // Monitor: samples 1 time unit after each active edge.
   initial begin
      exp_t e;
      int   ph;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ph = phase_q.pop_front();
            check($sformatf("seg_p%0d", ph), int'(seg_out), int'(e.seg));
            check($sformatf("dp_p%0d", ph), int'(dp_out), int'(e.dp));
            check($sformatf("dig_en_p%0d", ph), int'(dig_en), int'(e.dig));
            check($sformatf("frame_start_p%0d", ph), int'(frame_start), int'(e.fs));
            check($sformatf("onehot_p%0d", ph), int'($onehot0(dig_en)), 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] rd;
      int          nz;
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

      phase = 1;
      repeat (3) cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
      idle(2 * FRAME);

      phase = 2;
      idle(5);
      do_load(16'h1234, 4'b0100);
      idle(2 * FRAME);

      phase = 3;
      cur_lz = 1'b1;
      do_load(16'h0070, 4'b0000);
      idle(2 * FRAME);
      cur_lz = 1'b0;
      idle(FRAME);

      phase = 4;
      do_load(16'hA9F0, 4'b0000);
      idle(2 * FRAME);

      phase = 5;
      idle_until(2 * SD + 3);
      do_load(16'h5555, 4'b0000);
      idle_until(FRAME - 1);
      do_load(16'h9999, 4'b0000);
      idle(2 * FRAME + 4);

      phase = 6;
      idle_until(2 * SD + 4);
      cycle(1'b0, 1'b0, digits_in, dp_in, cur_lz);
      idle(FRAME + 4);

      phase = 7;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 15) == 0) cur_lz = ~cur_lz;
         if ($urandom_range(0, 249) == 0) begin
            cycle(1'b0, 1'b0, digits_in, dp_in, cur_lz);
         end else if ($urandom_range(0, 9) == 0) begin
            rd = 16'($urandom);
            nz = $urandom_range(0, 4);
            for (int k = 0; k < nz; k++) rd[15 - 4*k -: 4] = 4'h0;
            do_load(rd, 4'($urandom));
         end else begin
            idle(1);
         end
      end

      idle(3);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
